// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_pkg
// Description : Shared types and instruction field positions for the Hack core.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_pkg;

    localparam int HACK_WIDTH = 16;
    localparam int HACK_AW    = 15;

    // Instruction word field positions
    localparam int C_BIT   = 15;
    localparam int A_BIT   = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JLT     = 2;
    localparam int JEQ     = 1;
    localparam int JGT     = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational Hack ALU (zx/nx/zy/ny/f/no control, zr/ng flags).
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] w_x_z;
    logic [WIDTH-1:0] w_x_n;
    logic [WIDTH-1:0] w_y_z;
    logic [WIDTH-1:0] w_y_n;
    logic [WIDTH-1:0] w_fn;

    assign w_x_z = zx ? '0 : x;
    assign w_x_n = nx ? ~w_x_z : w_x_z;
    assign w_y_z = zy ? '0 : y;
    assign w_y_n = ny ? ~w_y_z : w_y_z;
    // Carry out of the adder is intentionally dropped
    assign w_fn  = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    assign out   = no ? ~w_fn : w_fn;
    assign zr    = (out == '0);
    assign ng    = out[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/hack_cpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : hack_cpu_seq
// Description : Multi-cycle Hack CPU core (FETCH/EXEC/WB) driving a shared ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_cpu_seq
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_WIDTH,
    parameter int AW    = HACK_AW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [WIDTH-1:0] inM,
    output logic [WIDTH-1:0] outM,
    output logic             writeM,
    output logic [AW-1:0]    addressM,
    output logic [AW-1:0]    pc,
    output logic             retire
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic             r_rz;
    logic             r_rn;
    logic [AW-1:0]    r_pc;

    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_alu_out;
    logic             w_zr;
    logic             w_ng;
    logic             w_is_c;
    logic             w_jump;

    assign w_is_c = r_ir[C_BIT];
    assign w_y    = r_ir[A_BIT] ? inM : r_a;

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .x   (r_d),
        .y   (w_y),
        .zx  (r_ir[CTRL_HI]),
        .nx  (r_ir[CTRL_HI-1]),
        .zy  (r_ir[CTRL_HI-2]),
        .ny  (r_ir[CTRL_HI-3]),
        .f   (r_ir[CTRL_LO+1]),
        .no  (r_ir[CTRL_LO]),
        .out (w_alu_out),
        .zr  (w_zr),
        .ng  (w_ng)
    );

    assign w_jump = w_is_c && ((r_ir[JLT] && r_rn) ||
                               (r_ir[JEQ] && r_rz) ||
                               (r_ir[JGT] && !r_rn && !r_rz));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (inst_valid) w_state_nxt = inst[C_BIT] ? EXEC : WB;
            EXEC:    w_state_nxt = WB;
            WB:      w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    // State and architectural registers; A-instructions skip EXEC entirely
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_ir    <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_rz    <= 1'b0;
            r_rn    <= 1'b0;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == FETCH && inst_valid) begin
                r_ir <= inst;
            end
            if (r_state == EXEC) begin
                r_r  <= w_alu_out;
                r_rz <= w_zr;
                r_rn <= w_ng;
            end
            if (r_state == WB) begin
                r_pc <= w_jump ? r_a[AW-1:0] : r_pc + AW'(1);
                if (!w_is_c) begin
                    r_a <= WIDTH'(r_ir[AW-1:0]);
                end else begin
                    if (r_ir[DEST_A]) r_a <= r_r;
                    if (r_ir[DEST_D]) r_d <= r_r;
                end
            end
        end
    end

    assign inst_ready = (r_state == FETCH) && !reset;
    assign retire     = (r_state == WB);
    assign writeM     = (r_state == WB) && w_is_c && r_ir[DEST_M];
    assign outM       = r_r;
    assign addressM   = r_a[AW-1:0];
    assign pc         = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_hack_cpu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_cpu_seq
// Description : Directed scoreboard bench for the multi-cycle Hack core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_cpu_seq;

    logic        clock;
    logic        reset;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inM;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;
    logic        retire;

    typedef struct {
        string       tag;
        logic [14:0] exp_pc;
        logic [14:0] exp_addr;
        logic        exp_wm;
        logic [15:0] exp_outm;
        int          exp_lat;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   last_hs = 0;
    int   wm_cnt  = 0;
    int   rt_cnt  = 0;
    int   t0;

    hack_cpu_seq #(
        .WIDTH (16),
        .AW    (15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inM        (inM),
        .outM       (outM),
        .writeM     (writeM),
        .addressM   (addressM),
        .pc         (pc),
        .retire     (retire)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (writeM === 1'b1) wm_cnt++;
        if (retire === 1'b1) rt_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, then compare against the scoreboard entry when it retires
    task automatic issue(input logic [15:0] w, input logic [15:0] m, input logic [14:0] epc,
                         input logic [14:0] eaddr, input logic ewm, input logic [15:0] eout,
                         input string tag);
        exp_t e;
        int   k;
        e.tag      = tag;
        e.exp_pc   = epc;
        e.exp_addr = eaddr;
        e.exp_wm   = ewm;
        e.exp_outm = eout;
        e.exp_lat  = w[15] ? 2 : 1;
        sb.push_back(e);

        @(negedge clock);
        for (int i = 0; i < 10 && inst_ready !== 1'b1; i++) @(negedge clock);
        check({tag, "_ready"}, 32'(inst_ready), 32'd1);
        inst       = w;
        inM        = m;
        inst_valid = 1'b1;
        last_hs    = cyc;
        @(posedge clock);
        #1 inst_valid = 1'b0;

        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (retire === 1'b1) begin
                k = i;
                break;
            end
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(k), 32'(e.exp_lat));
        check({e.tag, "_writeM"}, 32'(writeM), 32'(e.exp_wm));
        if (e.exp_wm) begin
            check({e.tag, "_outM"}, 32'(outM), 32'(e.exp_outm));
            check({e.tag, "_addrWB"}, 32'(addressM), 32'(e.exp_addr));
        end
        @(posedge clock);
        #1;
        check({e.tag, "_pc"}, 32'(pc), 32'(e.exp_pc));
        check({e.tag, "_addr"}, 32'(addressM), 32'(e.exp_addr));
    endtask

    initial begin
        reset      = 1'b0;
        inst       = 16'h0000;
        inst_valid = 1'b0;
        inM        = 16'h0000;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_async_pc", 32'(pc), 32'd0);
        check("rst_ready_low", 32'(inst_ready), 32'd0);
        #24 reset = 1'b0;
        @(negedge clock);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_addr", 32'(addressM), 32'd0);
        check("rst_writeM", 32'(writeM), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_outM", 32'(outM), 32'd0);
        check("rst_ready", 32'(inst_ready), 32'd1);

        // A-instruction then D=A
        issue(16'h0011, 16'h0000, 15'd1, 15'h0011, 1'b0, 16'h0000, "a_0011");
        t0 = last_hs;
        issue(16'hEC10, 16'h0000, 15'd2, 15'h0011, 1'b0, 16'h0000, "d_eq_a");
        check("two_inst_cycles", 32'(cyc - t0), 32'd5);

        // D=D+A then M=D
        issue(16'h0003, 16'h0000, 15'd3, 15'h0003, 1'b0, 16'h0000, "a_0003");
        issue(16'hE090, 16'h0000, 15'd4, 15'h0003, 1'b0, 16'h0000, "d_plus_a");
        issue(16'hE308, 16'h0000, 15'd5, 15'h0003, 1'b1, 16'h0014, "store_14");

        // Jumps
        issue(16'h0007, 16'h0000, 15'd6, 15'h0007, 1'b0, 16'h0000, "a_0007");
        issue(16'hEA87, 16'h0000, 15'd7, 15'h0007, 1'b0, 16'h0000, "jmp");
        issue(16'hEA90, 16'h0000, 15'd8, 15'h0007, 1'b0, 16'h0000, "d_zero");
        issue(16'hE301, 16'h0000, 15'd9, 15'h0007, 1'b0, 16'h0000, "jgt_not");
        issue(16'hEE90, 16'h0000, 15'd10, 15'h0007, 1'b0, 16'h0000, "d_neg1");
        issue(16'h0020, 16'h0000, 15'd11, 15'h0020, 1'b0, 16'h0000, "a_0020");
        issue(16'hE304, 16'h0000, 15'h0020, 15'h0020, 1'b0, 16'h0000, "jlt_taken");
        issue(16'hE308, 16'h0000, 15'h0021, 15'h0020, 1'b1, 16'hFFFF, "store_ffff");

        // Stall with inst_valid low
        inst_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_retire", 32'(retire), 32'd0);
        end
        check("stall_pc", 32'(pc), 32'h0021);
        check("stall_ready", 32'(inst_ready), 32'd1);

        // M operand
        issue(16'hFC10, 16'h1234, 15'h0022, 15'h0020, 1'b0, 16'h0000, "d_eq_m");
        issue(16'hE308, 16'h0000, 15'h0023, 15'h0020, 1'b1, 16'h1234, "store_1234");

        // Reset while M=D sits in EXEC
        @(negedge clock);
        inst       = 16'hE308;
        inst_valid = 1'b1;
        @(posedge clock);
        #1 inst_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_exec_pc", 32'(pc), 32'd0);
        check("rst_exec_writeM", 32'(writeM), 32'd0);
        check("rst_exec_retire", 32'(retire), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        check("rst_exec_ready", 32'(inst_ready), 32'd1);
        check("rst_exec_addr", 32'(addressM), 32'd0);

        issue(16'h0005, 16'h0000, 15'd1, 15'h0005, 1'b0, 16'h0000, "post_rst_a");
        issue(16'hE308, 16'h0000, 15'd2, 15'h0005, 1'b1, 16'h0000, "post_rst_store");

        // pc wrap from 0x7FFF
        issue(16'h7FFF, 16'h0000, 15'd3, 15'h7FFF, 1'b0, 16'h0000, "a_7fff");
        issue(16'hEA87, 16'h0000, 15'h7FFF, 15'h7FFF, 1'b0, 16'h0000, "jmp_7fff");
        issue(16'h0001, 16'h0000, 15'h0000, 15'h0001, 1'b0, 16'h0000, "pc_wrap");

        @(negedge clock);
        check("writeM_pulses", 32'(wm_cnt), 32'd4);
        check("retire_pulses", 32'(rt_cnt), 32'd20);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
